mixcol_word_sequencer: RTL and testbench
========================================

# mixcol_word_sequencer

Sequences a shared 32-bit column unit (InvMixColumns) across the four words of a 128-bit AES state. On a start pulse it latches the state and presents one word at a time to the external column unit. It then writes each returned word back into the matching position of a 128-bit result register and pulses done. It sits between the AES control FSM and the single column-unit instance, so one 32-bit unit serves the whole state.

## Interface

- LAT, 0: latency in cycles of the external column unit; legal range 0..3; 0 means combinational.
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- data_in  in  128  state to process; latched on an accepted start.
- col_in  out  32  word presented to the column unit.
- col_issue  out  1  high in the first cycle each word is presented.
- col_out  in  32  column unit result; valid LAT cycles after col_issue.
- data_out  out  128  result register.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; data_out complete.
- abort  in  1  present only with MIXSEQ_ABORT_EN.

## Operation

- Word k (k = 0..3) is bits [127-32k : 96-32k], so word 0 is [127:96].
- The same k maps input word to output word.
- States:
  - IDLE: start=1 latches data_in into src_q, clears idx=0 and wcnt=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: col_in = src_q word idx. col_issue = (wcnt==0).
    - If wcnt==LAT: data_out word idx <= col_out and wcnt <= 0. If idx==3, go to DONE; otherwise idx <= idx+1.
    - Otherwise wcnt <= wcnt+1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start in RUN or DONE is ignored; it is not queued.
- data_in may change freely after acceptance; only src_q is used.
- data_out is not cleared at start. Words are overwritten in order 0..3 and the register holds its value indefinitely after done.
- col_in = 0 outside RUN.
- idx is 2 bits and wcnt is 2 bits; no wrap occurs beyond idx==3 because the RUN exit takes priority.
- RESET (at any time, including mid-RUN) forces IDLE with idx=0, wcnt=0, src_q=0, data_out=0, done=0, busy=0, col_issue=0, col_in=0. Reset takes priority over start.

## Timing

- Reset values: all outputs 0.
- Start accepted at edge E0. RUN occupies the 4*(LAT+1) cycles after E0.
- Word k is captured at edge E0 + (k+1)*(LAT+1).
- done is high in the cycle after the final capture edge. That is cycle 4*(LAT+1)+1 after E0; with LAT=0 it is cycle 5.
- The next start is accepted at the earliest in the cycle after done (IDLE). Back-to-back throughput is one operation per 4*(LAT+1)+2 cycles.
- col_in is stable for all LAT+1 cycles of its word, so the column unit need not register its input.

## Configuration

- MIXSEQ_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in RUN or DONE forces IDLE on the next edge with no done pulse. data_out keeps any words already written, and idx and wcnt clear.
  - abort in IDLE has no effect. abort and start in the same IDLE cycle: start wins.
  - RESET overrides abort.
- MIXSEQ_ABORT_EN undefined: no abort port; RUN always completes.

## Test plan

- Reset: assert RESET 2 cycles, then release. All outputs are 0 and busy=0.
- LAT=0 with stub col_out = ~col_in, data_in = 0x00112233_44556677_8899AABB_CCDDEEFF, start pulse:
  - done is high exactly at cycle 5 after the start edge.
  - data_out = 0xFFEEDDCC_BBAA9988_77665544_33221100.
  - col_issue is high 4 times.
- LAT=2 with a 2-stage registered stub, same vector:
  - each col_in is held 3 cycles.
  - done at cycle 13.
  - same data_out.
- start held high continuously plus data_in changed mid-RUN:
  - result matches the originally latched value.
  - the second operation begins only in the cycle after done.
- RESET asserted at cycle 3 of RUN (LAT=0): the next cycle shows busy=0 and data_out=0, and no done pulse ever appears for that run.
- With MIXSEQ_ABORT_EN and LAT=1, abort at cycle 4:
  - words 0 and 1 are written; words 2 and 3 keep their previous value.
  - no done pulse; IDLE on the next edge.
  - a new start then completes normally.

Source files
------------

// File: rtl/mixcol_word_sequencer.sv
// mixcol_word_sequencer
// Time-multiplexes one external 32-bit InvMixColumns unit across the four words of a
// 128-bit AES state. A start pulse latches the state. Each word is then presented for
// LAT+1 cycles, and the returned word is written into the result register. Word 0 is
// bits [127:96]. A one-cycle done pulse follows the last write-back.
//
// Optional feature: define MIXSEQ_ABORT_EN to add the i_abort port. When abort is high
// in RUN or DONE, the sequencer returns to IDLE without a done pulse.
`timescale 1ns/1ps

module mixcol_word_sequencer #(
  parameter int unsigned LAT = 0  // column-unit latency, 0..3 (0 = combinational)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [127:0] i_data_in,
  output logic [31:0]  o_col_in,
  output logic         o_col_issue,
  input  logic [31:0]  i_col_out,
  output logic [127:0] o_data_out,
  output logic         o_busy,
  output logic         o_done
`ifdef MIXSEQ_ABORT_EN
  ,
  input  logic         i_abort
`endif
);

  // wcnt is only two bits wide, so a latency above 3 can never be reached
  if (LAT > 3) begin : g_bad_lat
    $error("mixcol_word_sequencer: LAT must be in 0..3");
  end

  localparam logic [1:0] LatLast = 2'(LAT);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e       r_state;
  state_e       w_state_next;
  logic [127:0] r_src;
  logic [127:0] r_data_out;
  logic [1:0]   r_idx;
  logic [1:0]   r_wcnt;

  logic         w_abort;
  logic         w_last_beat;
  logic         w_last_word;
  logic         w_capture;
  logic [31:0]  w_word;

`ifdef MIXSEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // The column unit's result is valid on the last beat of each word
  assign w_last_beat = (r_wcnt == LatLast);
  assign w_last_word = (r_idx == 2'd3);
  // An abort still captures a word that completes in the same cycle
  assign w_capture   = (r_state == StRun) && w_last_beat;

  // Select latched source word idx; word 0 is the most significant
  always_comb begin
    w_word = r_src[127:96];
    unique case (r_idx)
      2'd0: w_word = r_src[127:96];
      2'd1: w_word = r_src[95:64];
      2'd2: w_word = r_src[63:32];
      2'd3: w_word = r_src[31:0];
      default: w_word = r_src[127:96];
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; the RUN exit takes priority so idx never wraps past 3
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_abort) begin
          w_state_next = StIdle;
        end else if (w_last_beat && w_last_word) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Source latch plus word index and beat counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_src  <= '0;
      r_idx  <= 2'd0;
      r_wcnt <= 2'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_src  <= i_data_in;
            r_idx  <= 2'd0;
            r_wcnt <= 2'd0;
          end
        end
        StRun: begin
          if (w_abort) begin
            r_idx  <= 2'd0;
            r_wcnt <= 2'd0;
          end else if (w_last_beat) begin
            r_wcnt <= 2'd0;
            if (!w_last_word) begin
              r_idx <= r_idx + 2'd1;
            end
          end else begin
            r_wcnt <= r_wcnt + 2'd1;
          end
        end
        StDone: begin
          r_idx  <= 2'd0;
          r_wcnt <= 2'd0;
        end
        default: begin
          r_idx  <= 2'd0;
          r_wcnt <= 2'd0;
        end
      endcase
    end
  end

  // Result register: not cleared on start, one word overwritten per capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_out <= '0;
    end else if (w_capture) begin
      unique case (r_idx)
        2'd0: r_data_out[127:96] <= i_col_out;
        2'd1: r_data_out[95:64]  <= i_col_out;
        2'd2: r_data_out[63:32]  <= i_col_out;
        2'd3: r_data_out[31:0]   <= i_col_out;
        default: r_data_out[127:96] <= i_col_out;
      endcase
    end
  end

  // Outputs decoded from state; col_in is held for all beats of a word
  always_comb begin
    o_col_in    = 32'd0;
    o_col_issue = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_busy = 1'b0;
      end
      StRun: begin
        o_col_in    = w_word;
        o_col_issue = (r_wcnt == 2'd0);
        o_busy      = 1'b1;
      end
      StDone: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  assign o_data_out = r_data_out;

endmodule

// File: tb/tb_mixcol_word_sequencer.sv
// Bench for mixcol_word_sequencer: three instances (LAT = 0, 1, 2) share one stimulus
// stream, each driving its own stub column unit that returns ~col_in after LAT cycles.
// A cycle-count model predicts every output of every instance each cycle.
`timescale 1ns/1ps

module tb_mixcol_word_sequencer;

  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [127:0] data_in;

  logic [31:0]  col_in_a  [NI];
  logic [31:0]  col_out_a [NI];
  logic         issue_a   [NI];
  logic         busy_a    [NI];
  logic         done_a    [NI];
  logic [127:0] dout_a    [NI];

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mixcol_word_sequencer #(.LAT(g)) u_dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_start     (start),
      .i_data_in   (data_in),
      .o_col_in    (col_in_a[g]),
      .o_col_issue (issue_a[g]),
      .i_col_out   (col_out_a[g]),
      .o_data_out  (dout_a[g]),
      .o_busy      (busy_a[g]),
      .o_done      (done_a[g])
`ifdef MIXSEQ_ABORT_EN
      ,
      .i_abort     (abort)
`endif
    );

    if (g == 0) begin : g_comb
      assign col_out_a[g] = ~col_in_a[g];
    end else begin : g_pipe
      logic [31:0] pipe [g];
      always @(posedge clk) begin
        pipe[0] <= ~col_in_a[g];
        for (int s = 1; s < g; s++) pipe[s] <= pipe[s-1];
      end
      assign col_out_a[g] = pipe[g-1];
    end
  end

  // ---------------- behavioural model ----------------
  // m_cyc = 0 when idle, else the cycle number counted from the accepting edge
  int           m_cyc  [NI];
  logic [127:0] m_src  [NI];
  logic [127:0] m_dout [NI];

  function automatic int run_len(input int lat);
    return 4 * (lat + 1);
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] v, input int k);
    return v[127 - 32*k -: 32];
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] v, input int k,
                                            input logic [31:0] w);
    logic [127:0] r;
    r = v;
    r[127 - 32*k -: 32] = w;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_cyc[i]  <= 0;
        m_src[i]  <= '0;
        m_dout[i] <= '0;
      end else if (m_cyc[i] == 0) begin
        if (start) begin
          m_cyc[i] <= 1;
          m_src[i] <= data_in;
        end
      end else begin
        if (m_cyc[i] <= run_len(i) && (m_cyc[i] % (i + 1)) == 0)
          m_dout[i] <= put_word(m_dout[i], m_cyc[i] / (i + 1) - 1,
                                ~word_of(m_src[i], m_cyc[i] / (i + 1) - 1));
        if (abort || m_cyc[i] == run_len(i) + 1) m_cyc[i] <= 0;
        else m_cyc[i] <= m_cyc[i] + 1;
      end
    end
  end

  function automatic logic [31:0] exp_col_in(input int c, input int lat, input logic [127:0] s);
    if (c >= 1 && c <= run_len(lat)) return word_of(s, (c - 1) / (lat + 1));
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Compare every instance against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("busy%0d", i), 128'(busy_a[i]), 128'(m_cyc[i] > 0));
        check($sformatf("done%0d", i), 128'(done_a[i]), 128'(m_cyc[i] == run_len(i) + 1));
        check($sformatf("issue%0d", i), 128'(issue_a[i]),
              128'(m_cyc[i] >= 1 && m_cyc[i] <= run_len(i) && ((m_cyc[i] - 1) % (i + 1)) == 0));
        check($sformatf("col_in%0d", i), 128'(col_in_a[i]),
              128'(exp_col_in(m_cyc[i], i, m_src[i])));
        check($sformatf("data_out%0d", i), dout_a[i], m_dout[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int           done_at [NI];
  int           n_iss   [NI];
  int           n_run   [NI];
  int           d0;
  int           nd;
  logic         b1;
  logic         b2;
  logic [127:0] vec;
  logic [127:0] vec_inv;
  logic [127:0] orig;
  logic [127:0] dout_at_done;
`ifdef MIXSEQ_ABORT_EN
  logic [127:0] prev;
  logic [127:0] vec2;
`endif

  initial begin
    vec     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    vec_inv = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    rst = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;

    // Reset for two edges, then release
    cycle();
    chk_en = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_busy%0d", i), 128'(busy_a[i]), 128'(0));
      check($sformatf("rst_done%0d", i), 128'(done_a[i]), 128'(0));
      check($sformatf("rst_issue%0d", i), 128'(issue_a[i]), 128'(0));
      check($sformatf("rst_col_in%0d", i), 128'(col_in_a[i]), 128'(0));
      check($sformatf("rst_data_out%0d", i), dout_a[i], 128'(0));
    end

    // Directed operation with the reference vector
    for (int i = 0; i < NI; i++) begin
      done_at[i] = 0; n_iss[i] = 0; n_run[i] = 0;
    end
    data_in = vec; start = 1'b1;
    cycle();
    start = 1'b0; data_in = rand128();
    for (int c = 1; c <= 20; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (done_a[i] && done_at[i] == 0) done_at[i] = c;
        if (issue_a[i]) n_iss[i]++;
        if (busy_a[i] && !done_a[i]) n_run[i]++;
      end
      cycle();
    end
    check("done_cycle_lat0", 128'(done_at[0]), 128'(5));
    check("done_cycle_lat1", 128'(done_at[1]), 128'(9));
    check("done_cycle_lat2", 128'(done_at[2]), 128'(13));
    check("run_cycles_lat2", 128'(n_run[2]), 128'(12));
    for (int i = 0; i < NI; i++) begin
      check($sformatf("issue_count%0d", i), 128'(n_iss[i]), 128'(4));
      check($sformatf("vec_result%0d", i), dout_a[i], vec_inv);
    end

    // Start held high while data_in churns
    orig = rand128();
    data_in = orig; start = 1'b1;
    cycle();
    d0 = 0; b1 = 1'b1; b2 = 1'b0; dout_at_done = '0;
    for (int c = 1; c <= 30; c++) begin
      data_in = rand128();
      if (done_a[0] && d0 == 0) begin
        d0 = c;
        dout_at_done = dout_a[0];
      end
      if (d0 != 0 && c == d0 + 1) b1 = busy_a[0];
      if (d0 != 0 && c == d0 + 2) b2 = busy_a[0];
      cycle();
    end
    check("held_done_cycle", 128'(d0), 128'(5));
    check("held_result", dout_at_done, ~orig);
    check("held_idle_after_done", 128'(b1), 128'(0));
    check("held_restart", 128'(b2), 128'(1));
    start = 1'b0;
    repeat (16) cycle();

    // Reset in cycle 3 of a LAT=0 run
    data_in = vec; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    check("midrst_busy", 128'(busy_a[0]), 128'(0));
    check("midrst_data_out", dout_a[0], 128'(0));
    rst = 1'b0;
    nd = 0;
    repeat (20) begin
      if (done_a[0]) nd++;
      cycle();
    end
    check("midrst_no_done", 128'(nd), 128'(0));

    // Randomized traffic checked by the model
    repeat (800) begin
      start   = ($urandom_range(0, 3) == 0);
      data_in = rand128();
`ifdef MIXSEQ_ABORT_EN
      abort   = ($urandom_range(0, 19) == 0);
`endif
      rst     = ($urandom_range(0, 249) == 0);
      cycle();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (16) cycle();

`ifdef MIXSEQ_ABORT_EN
    // Abort in cycle 4 of a LAT=1 run: words 0 and 1 land, 2 and 3 keep old value
    prev = m_dout[1];
    data_in = vec; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_idle", 128'(busy_a[1]), 128'(0));
    check("abort_partial", dout_a[1], {vec_inv[127:64], prev[63:0]});
    nd = 0;
    repeat (16) begin
      if (done_a[1]) nd++;
      cycle();
    end
    check("abort_no_done", 128'(nd), 128'(0));
    vec2 = rand128();
    data_in = vec2; start = 1'b1;
    cycle();
    start = 1'b0;
    d0 = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done_a[1] && d0 == 0) d0 = c;
      cycle();
    end
    check("abort_restart_done", 128'(d0), 128'(9));
    check("abort_restart_result", dout_a[1], ~vec2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
